// File: rtl/ring_freq_meter.sv
// ring_freq_meter: gates a ring oscillator for a programmed number of clk cycles
// and reports the count of ring rising edges as a frequency word.
// Ports:
//   i_clk    system clock
//   i_rn     asynchronous active-low reset
//   i_start  measurement request, sampled in IDLE only
//   i_gate   gate length in clk cycles, sampled with i_start
//   i_ring   ring oscillator output, clocks the edge counter
//   o_en     ring enable (registered)
//   o_busy   measurement in progress
//   o_done   one-cycle pulse when o_result/o_ovf update
//   o_result captured edge count
//   o_ovf    edge counter saturated during the last measurement
module ring_freq_meter #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 12,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rn,
    input  logic              i_start,
    input  logic [GATE_W-1:0] i_gate,
    input  logic              i_ring,
    output logic              o_en,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_result,
    output logic              o_ovf
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, CAPTURE} state_t;
    state_t            r_state;
    state_t            w_next;
    logic [GATE_W-1:0] r_gcnt;
    logic              r_en;
    logic              r_clr;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_result;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_ring_cnt;
    logic              r_ring_ovf;
    logic              w_ring_clr;
    logic              w_en_nxt;
    logic              w_clr_nxt;
    logic              w_busy_nxt;
    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? CLEAR : IDLE;
            CLEAR:   w_next = (r_gcnt == '0) ? SETTLE : RUN;
            RUN:     w_next = (r_gcnt == GATE_W'(1)) ? SETTLE : RUN;
            SETTLE:  w_next = (r_gcnt == GATE_W'(1)) ? CAPTURE : SETTLE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // Outputs are decoded from the next state and registered so they are glitch-free.
    always_comb begin
        w_en_nxt   = (w_next == RUN);
        w_clr_nxt  = (w_next == CLEAR);
        w_busy_nxt = (w_next != IDLE);
    end
    // r_gcnt counts the gate in RUN and is reloaded to time the SETTLE window.
    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_gcnt   <= '0;
            r_en     <= 1'b0;
            r_clr    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_en   <= w_en_nxt;
            r_clr  <= w_clr_nxt;
            r_busy <= w_busy_nxt;
            r_done <= (r_state == CAPTURE);
            if (r_state == IDLE && i_start)
                r_gcnt <= i_gate;
            else if (w_next == SETTLE && r_state != SETTLE)
                r_gcnt <= GATE_W'(SETTLE_CYCLES);
            else if (r_state == RUN || r_state == SETTLE)
                r_gcnt <= r_gcnt - GATE_W'(1);
            // The ring is stopped and the count static here, so the bus is sampled directly.
            if (r_state == CAPTURE) begin
                r_result <= r_ring_cnt;
                r_ovf    <= r_ring_ovf;
            end
        end
    end
    // Ring-domain counter; cleared asynchronously while the ring is held static.
    assign w_ring_clr = r_clr | ~i_rn;
    always_ff @(posedge i_ring or posedge w_ring_clr) begin
        if (w_ring_clr) begin
            r_ring_cnt <= '0;
            r_ring_ovf <= 1'b0;
        end else if (&r_ring_cnt) begin
            r_ring_ovf <= 1'b1;
        end else begin
            r_ring_cnt <= r_ring_cnt + CNT_W'(1);
        end
    end
    assign o_en     = r_en;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_ovf    = r_ovf;
endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter: scoreboard bench for ring_freq_meter with a behavioural ring
module tb_ring_freq_meter;
    localparam int CW = 8;
    localparam int GW = 12;
    logic          clk = 1'b0;
    logic          rn = 1'b1;
    logic          start = 1'b0;
    logic [GW-1:0] gate = '0;
    logic          ring;
    logic          en, busy, done, ovf;
    logic [CW-1:0] result;
    logic          rq = 1'b1;
    logic          fr = 1'b0;
    logic          free_mode = 1'b0;
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            en_total = 0;
    int            done_total = 0;
    typedef struct {
        int lo;
        int hi;
        bit ovf;
        int lat;
        int enc;
    } exp_t;
    exp_t sb[$];

    ring_freq_meter #(.CNT_W(CW), .GATE_W(GW), .SETTLE_CYCLES(4)) dut (
        .i_clk(clk), .i_rn(rn), .i_start(start), .i_gate(gate), .i_ring(ring),
        .o_en(en), .o_busy(busy), .o_done(done), .o_result(result), .o_ovf(ovf)
    );

    always #5 clk = ~clk;
    always #3 if (free_mode) fr = ~fr;
    // 4 ns ring, idle high while disabled
    always begin
        if (en === 1'b1) begin
            #2 rq = 1'b0;
            #2 rq = 1'b1;
        end else begin
            rq = 1'b1;
            @(posedge en);
        end
    end
    assign ring = free_mode ? fr : rq;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        en_total   <= en_total + ((en === 1'b1) ? 1 : 0);
        done_total <= done_total + ((done === 1'b1) ? 1 : 0);
    end

    task automatic do_meas(input int g, output int lat, output bit ok, output int enc);
        int c0, e0;
        @(negedge clk);
        start = 1'b1;
        gate  = GW'(g);
        c0 = cyc;
        e0 = en_total;
        @(negedge clk);
        start = 1'b0;
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (done === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - c0 - 1;
            end else @(negedge clk);
        end
        enc = en_total - e0;
    endtask

    task automatic test_reset();
        free_mode = 1'b1;
        #1 rn = 1'b0;
        repeat (5) @(negedge clk);
        tests++; if ({en, busy, done} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: en/busy/done=%b want 000", {en, busy, done}); end
        tests++; if ({result, ovf} !== '0) begin fails++; $display("FAIL reset_data: result=%0d ovf=%b want 0/0", result, ovf); end
        rn = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if ({en, busy, done} !== 3'b000) begin fails++; $display("FAIL post_reset_ctrl: en/busy/done=%b want 000", {en, busy, done}); end
        tests++; if ({result, ovf} !== '0) begin fails++; $display("FAIL post_reset_data: result=%0d ovf=%b want 0/0", result, ovf); end
        free_mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        int lat, enc;
        bit ok;
        sb.push_back(exp_t'{249, 251, 1'b0, 106, 100});
        do_meas(100, lat, ok, enc);
        e = sb.pop_front();
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_done: no DONE seen, want DONE"); end
        tests++; if (lat != e.lat) begin fails++; $display("FAIL basic_latency: got %0d want %0d", lat, e.lat); end
        tests++; if (enc != e.enc) begin fails++; $display("FAIL basic_en_cycles: got %0d want %0d", enc, e.enc); end
        tests++; if (int'(result) < e.lo || int'(result) > e.hi) begin fails++; $display("FAIL basic_result: got %0d want %0d..%0d", result, e.lo, e.hi); end
        tests++; if (ovf !== e.ovf) begin fails++; $display("FAIL basic_ovf: got %b want %b", ovf, e.ovf); end
        @(negedge clk);
        tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL basic_pulse: done/busy=%b want 00", {done, busy}); end
    endtask

    task automatic test_gate0();
        exp_t e;
        int lat, enc;
        bit ok;
        sb.push_back(exp_t'{0, 0, 1'b0, 6, 0});
        do_meas(0, lat, ok, enc);
        e = sb.pop_front();
        tests++; if (lat != e.lat) begin fails++; $display("FAIL gate0_latency: got %0d want %0d", lat, e.lat); end
        tests++; if (enc != e.enc) begin fails++; $display("FAIL gate0_en_cycles: got %0d want %0d", enc, e.enc); end
        tests++; if (int'(result) != e.lo || ovf !== e.ovf) begin fails++; $display("FAIL gate0_result: got %0d/%b want %0d/%b", result, ovf, e.lo, e.ovf); end
    endtask

    task automatic test_overflow();
        exp_t e;
        int lat, enc;
        bit ok;
        sb.push_back(exp_t'{255, 255, 1'b1, 206, 200});
        sb.push_back(exp_t'{24, 26, 1'b0, 16, 10});
        do_meas(200, lat, ok, enc);
        e = sb.pop_front();
        tests++; if (lat != e.lat) begin fails++; $display("FAIL ovf_latency: got %0d want %0d", lat, e.lat); end
        tests++; if (int'(result) != e.lo) begin fails++; $display("FAIL ovf_result: got %0d want %0d", result, e.lo); end
        tests++; if (ovf !== e.ovf) begin fails++; $display("FAIL ovf_flag: got %b want %b", ovf, e.ovf); end
        do_meas(10, lat, ok, enc);
        e = sb.pop_front();
        tests++; if (lat != e.lat) begin fails++; $display("FAIL ovf_clr_latency: got %0d want %0d", lat, e.lat); end
        tests++; if (int'(result) < e.lo || int'(result) > e.hi) begin fails++; $display("FAIL ovf_clr_result: got %0d want %0d..%0d", result, e.lo, e.hi); end
        tests++; if (ovf !== e.ovf) begin fails++; $display("FAIL ovf_clr_flag: got %b want %b", ovf, e.ovf); end
    endtask

    task automatic test_start_busy();
        exp_t e;
        int c0, e0, d0, lat;
        bit ok;
        sb.push_back(exp_t'{99, 101, 1'b0, 46, 40});
        @(negedge clk);
        start = 1'b1;
        gate  = GW'(40);
        c0 = cyc;
        e0 = en_total;
        d0 = done_total;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        gate  = GW'(5);
        @(negedge clk);
        start = 1'b0;
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (done === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - c0 - 1;
            end else @(negedge clk);
        end
        e = sb.pop_front();
        tests++; if (lat != e.lat) begin fails++; $display("FAIL busy_latency: got %0d want %0d", lat, e.lat); end
        tests++; if (en_total - e0 != e.enc) begin fails++; $display("FAIL busy_en_cycles: got %0d want %0d", en_total - e0, e.enc); end
        tests++; if (int'(result) < e.lo || int'(result) > e.hi) begin fails++; $display("FAIL busy_result: got %0d want %0d..%0d", result, e.lo, e.hi); end
        repeat (20) @(negedge clk);
        tests++; if (done_total - d0 != 1) begin fails++; $display("FAIL busy_single_done: got %0d pulses want 1", done_total - d0); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int c0, lat;
        bit ok;
        sb.push_back(exp_t'{19, 21, 1'b0, 14, 8});
        sb.push_back(exp_t'{19, 21, 1'b0, 14, 8});
        @(negedge clk);
        start = 1'b1;
        gate  = GW'(8);
        c0 = cyc;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ok  = 1'b0;
            lat = -1;
            for (int i = 0; i < 500 && !ok; i++) begin
                if (done === 1'b1) begin
                    ok  = 1'b1;
                    lat = cyc - c0 - 1;
                end else @(negedge clk);
            end
            if (k == 1) start = 1'b0;
            e = sb.pop_front();
            tests++; if (lat != e.lat) begin fails++; $display("FAIL b2b_latency_%0d: got %0d want %0d", k, lat, e.lat); end
            tests++; if (int'(result) < e.lo || int'(result) > e.hi) begin fails++; $display("FAIL b2b_result_%0d: got %0d want %0d..%0d", k, result, e.lo, e.hi); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_%0d: busy=%b want 0", k, busy); end
            c0 = cyc;
        end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_stop: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int lat, enc;
        bit ok;
        @(negedge clk);
        start = 1'b1;
        gate  = GW'(100);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        tests++; if (en !== 1'b1) begin fails++; $display("FAIL midrun_en_high: en=%b want 1", en); end
        #2 rn = 1'b0;
        #1;
        tests++; if ({en, busy, done} !== 3'b000) begin fails++; $display("FAIL midrun_async: en/busy/done=%b want 000", {en, busy, done}); end
        tests++; if ({result, ovf} !== '0) begin fails++; $display("FAIL midrun_data: result=%0d ovf=%b want 0/0", result, ovf); end
        repeat (3) @(negedge clk);
        rn = 1'b1;
        sb.push_back(exp_t'{249, 251, 1'b0, 106, 100});
        do_meas(100, lat, ok, enc);
        e = sb.pop_front();
        tests++; if (lat != e.lat) begin fails++; $display("FAIL midrun_rerun_latency: got %0d want %0d", lat, e.lat); end
        tests++; if (int'(result) < e.lo || int'(result) > e.hi) begin fails++; $display("FAIL midrun_rerun_result: got %0d want %0d..%0d", result, e.lo, e.hi); end
        tests++; if (enc != e.enc) begin fails++; $display("FAIL midrun_rerun_en: got %0d want %0d", enc, e.enc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gate0();
        test_overflow();
        test_start_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
Measurement stage that drives the enable input of the 7-stage NAND ring oscillator and consumes its output Q. On request, it opens the ring for a programmable number of CLK cycles and counts ring rising edges in the ring's own clock domain. After the ring has stopped, it transfers the count into the CLK domain. It reports the count as a frequency word, RESULT = edges per GATE CLK periods.

Parameters:
CNT_W, 16, width of ring edge counter and RESULT
GATE_W, 12, width of GATE input
SETTLE_CYCLES, 4, CLK cycles with EN low before capture (ring quiesce plus counter settle); minimum 2

Ports:
CLK  input  1  system clock; all control logic on rising edge
RN  input  1  asynchronous active-low reset
START  input  1  measurement request; sampled only in IDLE
GATE  input  GATE_W  gate length in CLK cycles; sampled with START
RING  input  1  ring oscillator output Q; used as clock of the edge counter
EN  output  1  ring oscillator enable; drives ring EN
BUSY  output  1  high from the cycle after START is accepted until DONE
DONE  output  1  one-cycle pulse when RESULT/OVF are updated
RESULT  output  CNT_W  captured rising-edge count of RING
OVF  output  1  count saturated during the last measurement

Behaviour:
- Reset (RN low, asynchronous): state IDLE, EN=0, BUSY=0, DONE=0, RESULT=0, OVF=0, gate counter=0, ring edge counter and ring-domain overflow flag cleared asynchronously. Reset mid-measurement aborts immediately. EN low forces all ring nodes high, so the ring stops with Q=1.
- FSM states: IDLE, CLEAR, RUN, SETTLE, CAPTURE.
- IDLE: EN=0, BUSY=0. START=1 at a rising edge latches GATE into gcnt and moves to CLEAR.
- CLEAR (1 cycle): BUSY=1, EN=0. The CLR register is high, which asynchronously clears the ring-domain counter and overflow flag. This is safe because RING is static. Next state is RUN, or SETTLE if the latched GATE == 0.
- RUN: EN=1 for exactly GATE CLK cycles; gcnt decrements each cycle. On the cycle gcnt reaches 1, move to SETTLE with EN=0 in the next cycle. EN is registered and glitch-free.
- SETTLE: EN=0 for SETTLE_CYCLES cycles. The counter is frozen, because the ring stops within a few gate delays.
- CAPTURE (1 cycle): RESULT <= ring counter and OVF <= ring overflow flag, both sampled directly. The value is static, so no synchronizer is needed on the multi-bit bus. DONE=1 for this cycle. Next state is IDLE, and BUSY=0 from the following cycle.
- Ring counter: increments on each RING rising edge. It saturates at 2^CNT_W-1 and sets the overflow flag, which is sticky until the next CLEAR.
- Latency: START edge to DONE = 1 + 1 + GATE + SETTLE_CYCLES cycles (GATE=0 gives 2 + SETTLE_CYCLES).
- START while BUSY: ignored, no queueing. START held high continuously: a new measurement begins on the cycle after returning to IDLE.
- GATE changes during a measurement have no effect.
- RESULT/OVF hold their value between measurements and change only in CAPTURE or on reset.
- No combinational path from any input to any output.

Test Plan:
1. Reset: hold RN low with RING toggling -> EN=0, BUSY=0, DONE=0, RESULT=0, OVF=0. Release RN -> all outputs remain at these values until START.
2. Basic measurement: CLK 10 ns, behavioural ring period 4 ns gated by EN, GATE=100, START pulse -> EN high exactly 100 cycles; DONE pulses 106 cycles after the START edge; RESULT in 249..251, OVF=0.
3. GATE=0 -> EN never rises; DONE pulses 6 cycles after START; RESULT=0, OVF=0.
4. Overflow: CNT_W=8, ring period 4 ns, GATE=200 -> RESULT=255, OVF=1. A following run with GATE=10 -> RESULT ~25, OVF=0 (the sticky flag is cleared by CLEAR).
5. START ignored while BUSY: second START during RUN -> single DONE; RESULT matches a single measurement. START held high -> back-to-back measurements separated by one IDLE cycle.
6. Reset mid-RUN: assert RN at gate cycle 50 -> EN falls asynchronously, RESULT=0, state IDLE. Next START with GATE=100 gives the same result as scenario 2.
